// File: rtl/mem_responder_if.sv
// mem_responder_if: request/response bundle between the multicycle control
// unit and the unified memory responder.
//   mem_read, mem_write : request strobes, held by the requester until ready
//   addr, wdata         : byte address and write data
//   rdata               : registered read data
//   ready               : one-cycle completion pulse
//   busy                : request in progress
//   err                 : illegal request flag, valid with ready
//   access_cnt          : count of successful accesses
interface mem_responder_if;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        busy;
  logic        err;
  logic [15:0] access_cnt;

  modport master (
    output mem_read, mem_write, addr, wdata,
    input  rdata, ready, busy, err, access_cnt
  );

  modport slave (
    input  mem_read, mem_write, addr, wdata,
    output rdata, ready, busy, err, access_cnt
  );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: word-organised unified instruction/data memory with a
// programmable number of wait states per access.
//   clk : clock, rising edge
//   rst : asynchronous active-low reset
//   bus : mem_responder_if.slave (strobes, addr, wdata in; rdata, ready,
//         busy, err, access_cnt out)
// Illegal requests (both strobes, misaligned, out of range) complete with
// the normal timing and err set, so the requester never hangs.
//
// state  | meaning
// S_IDLE | waiting for a strobe; captures the request
// S_WAIT | counting down wait states, then performs the access
// S_RESP | ready pulse cycle; returns to idle
module mem_responder #(
  parameter int ADDR_W = 8,
  parameter int WAIT   = 2
) (
  input logic             clk,
  input logic             rst,
  mem_responder_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t              state;
  logic [3:0]          wait_cnt;
  logic [ADDR_W-1:0]   idx_q;
  logic [31:0]         wdata_q;
  logic                op_wr_q;
  logic                bad_q;
  logic [31:0]         rdata_q;
  logic                ready_q;
  logic                busy_q;
  logic                err_q;
  logic [15:0]         cnt_q;
  logic                mem_we;
  logic                req_bad;

  logic [31:0] mem [0:DEPTH-1];

  assign req_bad = (bus.mem_read && bus.mem_write)
                 || (bus.addr[1:0] != 2'b00)
                 || (bus.addr[31:ADDR_W+2] != '0);

  // Write commits only on the access edge; an async reset during S_WAIT
  // forces state to idle so the pending write is dropped.
  assign mem_we = (state == S_WAIT) && (wait_cnt == 4'd0) && op_wr_q && !bad_q;

  // Array is deliberately not reset so contents survive a reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx_q] <= wdata_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      wait_cnt <= 4'd0;
      idx_q    <= '0;
      wdata_q  <= 32'd0;
      op_wr_q  <= 1'b0;
      bad_q    <= 1'b0;
      rdata_q  <= 32'd0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= 16'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.mem_read || bus.mem_write) begin
            idx_q    <= bus.addr[ADDR_W+1:2];
            wdata_q  <= bus.wdata;
            op_wr_q  <= bus.mem_write;
            bad_q    <= req_bad;
            wait_cnt <= 4'(WAIT);
            busy_q   <= 1'b1;
            err_q    <= 1'b0;
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
          end else begin
            ready_q <= 1'b1;
            state   <= S_RESP;
            if (bad_q) begin
              rdata_q <= 32'd0;
              err_q   <= 1'b1;
            end else begin
              // Writes leave rdata holding the last read value.
              if (!op_wr_q) begin
                rdata_q <= mem[idx_q];
              end
              err_q <= 1'b0;
              cnt_q <= cnt_q + 16'd1;
            end
          end
        end
        S_RESP: begin
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
          state   <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.rdata      = rdata_q;
  assign bus.ready      = ready_q;
  assign bus.busy       = busy_q;
  assign bus.err        = err_q;
  assign bus.access_cnt = cnt_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed stimulus with a scoreboard. The driver pushes
// the hand-computed response (data, err, count, completion cycle) for each
// request; a monitor pops and compares on every ready pulse.
module tb_mem_responder;

  localparam int WAIT = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_responder_if mbus();

  mem_responder #(.ADDR_W(8), .WAIT(WAIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (mbus)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic [15:0] cnt;
    int          cyc;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [15:0] exp_cnt = 16'd0;
  logic        prev_ready = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every ready pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (mbus.ready === 1'b1) begin
      chk("ready_one_cycle", {31'd0, prev_ready}, 32'd0);
      if (sbq.size() == 0) begin
        chk("unexpected_ready", 32'd1, 32'd0);
      end else begin
        mon_e = sbq.pop_front();
        chk("rdata", mbus.rdata, mon_e.rdata);
        chk("err", {31'd0, mbus.err}, {31'd0, mon_e.err});
        chk("access_cnt", {16'd0, mbus.access_cnt}, {16'd0, mon_e.cnt});
        chk("ready_cycle", cyc, mon_e.cyc);
        chk("busy_with_ready", {31'd0, mbus.busy}, 32'd1);
      end
    end
    prev_ready = mbus.ready;
  end

  // Issue a request at a negedge in idle. a2/wd2 replace addr/wdata one cycle
  // after sampling (must be ignored). n>1 holds the strobe through n accesses.
  task automatic req(input logic rd, input logic wr, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] a2,
                     input logic [31:0] wd2, input logic [31:0] exp_rd,
                     input logic exp_err, input int n);
    int   seen = 0;
    int   t = 0;
    exp_t e;
    mbus.mem_read  = rd;
    mbus.mem_write = wr;
    mbus.addr      = a;
    mbus.wdata     = wd;
    for (int k = 0; k < n; k++) begin
      if (!exp_err) exp_cnt = exp_cnt + 16'd1;
      e.rdata = exp_rd;
      e.err   = exp_err;
      e.cnt   = exp_cnt;
      e.cyc   = cyc + WAIT + 2 + k * (WAIT + 3);
      sbq.push_back(e);
    end
    while (seen < n && t < 50) begin
      @(negedge clk);
      t++;
      if (t == 1) begin
        mbus.addr  = a2;
        mbus.wdata = wd2;
      end
      if (mbus.ready === 1'b1) seen++;
    end
    if (seen < n) chk("req_timeout", seen, n);
    mbus.mem_read  = 1'b0;
    mbus.mem_write = 1'b0;
    @(negedge clk);
    chk("busy_after_resp", {31'd0, mbus.busy}, 32'd0);
  endtask

  task automatic go(input logic rd, input logic wr, input logic [31:0] a,
                    input logic [31:0] wd, input logic [31:0] exp_rd,
                    input logic exp_err);
    req(rd, wr, a, wd, a, wd, exp_rd, exp_err, 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rdata"}, mbus.rdata, 32'd0);
    chk({tag, "_ready"}, {31'd0, mbus.ready}, 32'd0);
    chk({tag, "_busy"}, {31'd0, mbus.busy}, 32'd0);
    chk({tag, "_err"}, {31'd0, mbus.err}, 32'd0);
    chk({tag, "_cnt"}, {16'd0, mbus.access_cnt}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    mbus.mem_read  = 1'b0;
    mbus.mem_write = 1'b0;
    mbus.addr      = 32'd0;
    mbus.wdata     = 32'd0;

    repeat (3) @(negedge clk);
    chk_reset_outputs("rst_held");
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs("rst_released");

    go(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    go(1'b1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    go(1'b1, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1);
    go(1'b0, 1'b1, 32'h20, 32'hCAFEF00D, 32'h0, 1'b0);
    go(1'b1, 1'b1, 32'h20, 32'h1, 32'h0, 1'b1);
    go(1'b1, 1'b0, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0);
    go(1'b1, 1'b0, 32'h400, 32'h0, 32'h0, 1'b1);

    // addr/wdata changed during WAIT must not be re-sampled
    go(1'b0, 1'b1, 32'h34, 32'h11112222, 32'h0, 1'b0);
    req(1'b0, 1'b1, 32'h30, 32'h33334444, 32'h34, 32'h55556666, 32'h0, 1'b0, 1);
    go(1'b1, 1'b0, 32'h30, 32'h0, 32'h33334444, 1'b0);
    go(1'b1, 1'b0, 32'h34, 32'h0, 32'h11112222, 1'b0);

    // Reset during WAIT of a write: write dropped, outputs cleared at once
    go(1'b0, 1'b1, 32'h20, 32'hAAAA5555, 32'h11112222, 1'b0);
    mbus.mem_write = 1'b1;
    mbus.addr      = 32'h20;
    mbus.wdata     = 32'h12345678;
    @(negedge clk);
    chk("mid_write_busy", {31'd0, mbus.busy}, 32'd1);
    rst = 1'b0;
    #1;
    chk_reset_outputs("rst_async");
    mbus.mem_write = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    exp_cnt = 16'd0;
    @(negedge clk);
    go(1'b1, 1'b0, 32'h20, 32'h0, 32'hAAAA5555, 1'b0);

    // Strobe held through RESP: next access only after resampling in idle
    req(1'b1, 1'b0, 32'h10, 32'h0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2);

    // Counter wrap: preload near the top instead of 65536 real accesses
    force dut.cnt_q = 16'hFFFE;
    @(negedge clk);
    release dut.cnt_q;
    exp_cnt = 16'hFFFE;
    @(negedge clk);
    go(1'b1, 1'b0, 32'h34, 32'h0, 32'h11112222, 1'b0);
    go(1'b1, 1'b0, 32'h30, 32'h0, 32'h33334444, 1'b0);
    chk("cnt_wrapped", {16'd0, mbus.access_cnt}, 32'd0);

    t = 0;
    while (sbq.size() != 0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("scoreboard_drained", sbq.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
